// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_pkg: shared types, constants and helpers for the 4x4 keypad scanner |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package keypad_pkg;

    localparam int KEYPAD_ROWS = 4;
    localparam int KEYPAD_COLS = 4;
    localparam int KEYPAD_KEYS = KEYPAD_ROWS * KEYPAD_COLS;

    typedef logic [3:0]             key_idx_t;
    typedef logic [KEYPAD_KEYS-1:0] key_vec_t;

    localparam logic [KEYPAD_ROWS-1:0] ROW_IDLE_INIT = 4'b1110;

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_SAMPLE = 1'b1
    } row_state_t;

    // Scanning downward leaves the lowest set index as the final winner.
    function automatic key_idx_t lowest_set(input key_vec_t v);
        key_idx_t idx;
        idx = '0;
        for (int i = KEYPAD_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = key_idx_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [4:0] count_ones(input key_vec_t v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEYPAD_KEYS; i++) begin
            cnt = cnt + {4'b0000, v[i]};
        end
        return cnt;
    endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_debounce: scan-to-scan debounce, release detect and event holding   |
// | Optional: KEYPAD_GHOST_REJECT_EN ignores candidates with more than 2 keys. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     scan_done,
    input  key_vec_t snapshot,
    output key_vec_t keys,
    output logic     event_valid,
    output key_idx_t event_key,
    input  logic     event_ready
);

    localparam logic [7:0] c_stable_max = 8'(DEBOUNCE_SCANS - 1);

    logic [7:0] r_stable;
    key_vec_t   r_last_raw;
    key_vec_t   r_keys;
    logic       r_ev_valid;
    key_idx_t   r_ev_key;

    logic       w_equal;
    logic [7:0] w_stable_next;
    logic       w_accept;
    logic       w_update;
    key_vec_t   w_release;

`ifdef KEYPAD_GHOST_REJECT_EN
    assign w_accept = (count_ones(snapshot) <= 5'd2);
`else
    assign w_accept = 1'b1;
`endif

    always_comb begin
        w_equal = (snapshot == r_last_raw);
        if (!w_equal) begin
            w_stable_next = '0;
        end else if (r_stable == c_stable_max) begin
            w_stable_next = r_stable;
        end else begin
            w_stable_next = r_stable + 8'd1;
        end
        w_update  = scan_done && (w_stable_next == c_stable_max) && w_accept;
        w_release = r_keys & ~snapshot;
    end

    // A pending ack takes priority: any release landing on that edge is lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stable   <= '0;
            r_last_raw <= '0;
            r_keys     <= '0;
            r_ev_valid <= 1'b0;
            r_ev_key   <= '0;
        end else begin
            if (scan_done) begin
                r_stable <= w_stable_next;
                if (!w_equal) begin
                    r_last_raw <= snapshot;
                end
            end
            if (w_update) begin
                r_keys <= snapshot;
            end
            if (r_ev_valid && event_ready) begin
                r_ev_valid <= 1'b0;
            end else if (!r_ev_valid && w_update && (w_release != '0)) begin
                r_ev_valid <= 1'b1;
                r_ev_key   <= lowest_set(w_release);
            end
        end
    end

    assign keys        = r_keys;
    assign event_valid = r_ev_valid;
    assign event_key   = r_ev_key;

endmodule : keypad_debounce
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_scanner: 4x4 active-low matrix scanner with debounced key output    |
// | Optional: KEYPAD_GHOST_REJECT_EN (handled in keypad_debounce).             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1200,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [3:0]  keypad_row,
    input  logic [3:0]  keypad_column,
    output logic [15:0] keys,
    output logic        event_valid,
    output logic [3:0]  event_key,
    input  logic        event_ready
);

    localparam logic [15:0] c_settle_last = 16'(SETTLE_CYCLES - 1);

    row_state_t  r_state;
    logic [15:0] r_count;
    logic [3:0]  r_row;
    logic [1:0]  r_row_idx;
    key_vec_t    r_raw;
    logic        r_scan_done;

    // r_scan_done is high in the cycle right after the row-3 sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_SETTLE;
            r_count     <= '0;
            r_row       <= ROW_IDLE_INIT;
            r_row_idx   <= '0;
            r_raw       <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                ST_SETTLE: begin
                    if (r_count == c_settle_last) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                ST_SAMPLE: begin
                    r_raw[{r_row_idx, 2'b00} +: KEYPAD_COLS] <= ~keypad_column;
                    r_row       <= {r_row[2:0], r_row[3]};
                    r_row_idx   <= r_row_idx + 2'd1;
                    r_count     <= '0;
                    r_state     <= ST_SETTLE;
                    r_scan_done <= (r_row_idx == 2'd3);
                end
                default: begin
                    r_state <= ST_SETTLE;
                end
            endcase
        end
    end

    assign keypad_row = r_row;

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clock       (clock),
        .reset       (reset),
        .scan_done   (r_scan_done),
        .snapshot    (r_raw),
        .keys        (keys),
        .event_valid (event_valid),
        .event_key   (event_key),
        .event_ready (event_ready)
    );

endmodule : keypad_scanner
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_keypad_scanner: directed bench, SETTLE_CYCLES=4, DEBOUNCE_SCANS=2       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_keypad_scanner;

    logic        clock;
    logic        reset;
    logic [3:0]  keypad_row;
    logic [3:0]  keypad_column;
    logic [15:0] keys;
    logic        event_valid;
    logic [3:0]  event_key;
    logic        event_ready;

    logic [15:0] pressed;
    int          total;
    int          bad;

    keypad_scanner #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .keypad_row    (keypad_row),
        .keypad_column (keypad_column),
        .keys          (keys),
        .event_valid   (event_valid),
        .event_key     (event_key),
        .event_ready   (event_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Matrix model: the driven row exposes its four keys as active-low columns.
    always_comb begin
        keypad_column = 4'b1111;
        case (keypad_row)
            4'b1110: keypad_column = ~pressed[3:0];
            4'b1101: keypad_column = ~pressed[7:4];
            4'b1011: keypad_column = ~pressed[11:8];
            4'b0111: keypad_column = ~pressed[15:12];
            default: keypad_column = 4'b1111;
        endcase
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at cycle 0: first cycle with reset low.
    task automatic do_reset(input logic [15:0] p);
        reset       = 1'b1;
        event_ready = 1'b0;
        pressed     = p;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_row;
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        event_ready = 1'b0;
        pressed     = 16'h0000;

        // Reset state
        tick(2);
        check("rst_row", 32'(keypad_row), 32'h0000000e);
        check("rst_keys", 32'(keys), 32'h0);
        check("rst_evv", 32'(event_valid), 32'h0);
        check("rst_evk", 32'(event_key), 32'h0);

        // Row sequence, no keys
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            case (k / 5)
                0: exp_row = 4'b1110;
                1: exp_row = 4'b1101;
                2: exp_row = 4'b1011;
                default: exp_row = 4'b0111;
            endcase
            check("row_seq", 32'(keypad_row), 32'(exp_row));
            tick(1);
        end
        check("row_wrap", 32'(keypad_row), 32'h0000000e);
        tick(22);
        check("idle_keys", 32'(keys), 32'h0);
        check("idle_evv", 32'(event_valid), 32'h0);

        // Reset mid-scan restarts row 0 with a fresh counter
        tick(7);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_row", 32'(keypad_row), 32'h0000000e);
        tick(4);
        check("midrst_row4", 32'(keypad_row), 32'h0000000e);
        tick(1);
        check("midrst_row5", 32'(keypad_row), 32'h0000000d);

        // Key 0xA held from cycle 0
        do_reset(16'h0400);
        tick(21);
        check("a_scan1", 32'(keys), 32'h0);
        tick(18);
        check("a_c39", 32'(keys), 32'h0);
        tick(2);
        check("a_c41", 32'(keys), 32'h00000400);
        check("a_evv", 32'(event_valid), 32'h0);

        // Key 5 pressed, debounced, released, acknowledged
        do_reset(16'h0020);
        tick(41);
        check("k5_down", 32'(keys), 32'h00000020);
        pressed = 16'h0000;
        tick(39);
        check("k5_c80_keys", 32'(keys), 32'h00000020);
        check("k5_c80_evv", 32'(event_valid), 32'h0);
        tick(1);
        check("k5_up_keys", 32'(keys), 32'h0);
        check("k5_up_evv", 32'(event_valid), 32'h1);
        check("k5_up_evk", 32'(event_key), 32'h5);
        tick(9);
        check("k5_hold_evv", 32'(event_valid), 32'h1);
        check("k5_hold_evk", 32'(event_key), 32'h5);
        event_ready = 1'b1;
        tick(1);
        event_ready = 1'b0;
        check("k5_ack_evv", 32'(event_valid), 32'h0);

        // Keys 3 and 0xC released together -> one event, lowest index
        do_reset(16'h1008);
        tick(41);
        check("k3c_down", 32'(keys), 32'h00001008);
        pressed = 16'h0000;
        tick(40);
        check("k3c_up_keys", 32'(keys), 32'h0);
        check("k3c_evv", 32'(event_valid), 32'h1);
        check("k3c_evk", 32'(event_key), 32'h3);
        event_ready = 1'b1;
        tick(1);
        event_ready = 1'b0;
        check("k3c_ack", 32'(event_valid), 32'h0);
        tick(60);
        check("k3c_no2nd", 32'(event_valid), 32'h0);

        // Key 7 toggling every scan never debounces
        do_reset(16'h0080);
        for (int s = 0; s < 6; s++) begin
            pressed = (s % 2 == 0) ? 16'h0080 : 16'h0000;
            tick(2);
            check("k7_keys", 32'(keys), 32'h0);
            check("k7_evv", 32'(event_valid), 32'h0);
            tick(18);
        end

        // Three keys held: ghost candidate
        do_reset(16'h0013);
        tick(41);
`ifdef KEYPAD_GHOST_REJECT_EN
        check("ghost_c41", 32'(keys), 32'h0);
        tick(40);
        check("ghost_c81", 32'(keys), 32'h0);
`else
        check("ghost_c41", 32'(keys), 32'h00000013);
        tick(40);
        check("ghost_c81", 32'(keys), 32'h00000013);
`endif
        check("ghost_evv", 32'(event_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_keypad_scanner
`default_nettype wire
